// File: rtl/axi_ram_arb2.sv
// Two-port AXI4 arbiter in front of a single AXI4 RAM slave.
// Write (AW/W/B) and read (AR/R) paths are arbitrated independently, round-robin, no buffering.
module axi_ram_arb2 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  // port 0
  input  logic [ID_WIDTH-1:0]   s0_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s0_axi_awaddr,
  input  logic [7:0]            s0_axi_awlen,
  input  logic [2:0]            s0_axi_awsize,
  input  logic [1:0]            s0_axi_awburst,
  input  logic                  s0_axi_awlock,
  input  logic [3:0]            s0_axi_awcache,
  input  logic [2:0]            s0_axi_awprot,
  input  logic                  s0_axi_awvalid,
  output logic                  s0_axi_awready,
  input  logic [DATA_WIDTH-1:0] s0_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s0_axi_wstrb,
  input  logic                  s0_axi_wlast,
  input  logic                  s0_axi_wvalid,
  output logic                  s0_axi_wready,
  output logic [ID_WIDTH-1:0]   s0_axi_bid,
  output logic [1:0]            s0_axi_bresp,
  output logic                  s0_axi_bvalid,
  input  logic                  s0_axi_bready,
  input  logic [ID_WIDTH-1:0]   s0_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s0_axi_araddr,
  input  logic [7:0]            s0_axi_arlen,
  input  logic [2:0]            s0_axi_arsize,
  input  logic [1:0]            s0_axi_arburst,
  input  logic                  s0_axi_arlock,
  input  logic [3:0]            s0_axi_arcache,
  input  logic [2:0]            s0_axi_arprot,
  input  logic                  s0_axi_arvalid,
  output logic                  s0_axi_arready,
  output logic [ID_WIDTH-1:0]   s0_axi_rid,
  output logic [DATA_WIDTH-1:0] s0_axi_rdata,
  output logic [1:0]            s0_axi_rresp,
  output logic                  s0_axi_rlast,
  output logic                  s0_axi_rvalid,
  input  logic                  s0_axi_rready,
  // port 1
  input  logic [ID_WIDTH-1:0]   s1_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s1_axi_awaddr,
  input  logic [7:0]            s1_axi_awlen,
  input  logic [2:0]            s1_axi_awsize,
  input  logic [1:0]            s1_axi_awburst,
  input  logic                  s1_axi_awlock,
  input  logic [3:0]            s1_axi_awcache,
  input  logic [2:0]            s1_axi_awprot,
  input  logic                  s1_axi_awvalid,
  output logic                  s1_axi_awready,
  input  logic [DATA_WIDTH-1:0] s1_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s1_axi_wstrb,
  input  logic                  s1_axi_wlast,
  input  logic                  s1_axi_wvalid,
  output logic                  s1_axi_wready,
  output logic [ID_WIDTH-1:0]   s1_axi_bid,
  output logic [1:0]            s1_axi_bresp,
  output logic                  s1_axi_bvalid,
  input  logic                  s1_axi_bready,
  input  logic [ID_WIDTH-1:0]   s1_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s1_axi_araddr,
  input  logic [7:0]            s1_axi_arlen,
  input  logic [2:0]            s1_axi_arsize,
  input  logic [1:0]            s1_axi_arburst,
  input  logic                  s1_axi_arlock,
  input  logic [3:0]            s1_axi_arcache,
  input  logic [2:0]            s1_axi_arprot,
  input  logic                  s1_axi_arvalid,
  output logic                  s1_axi_arready,
  output logic [ID_WIDTH-1:0]   s1_axi_rid,
  output logic [DATA_WIDTH-1:0] s1_axi_rdata,
  output logic [1:0]            s1_axi_rresp,
  output logic                  s1_axi_rlast,
  output logic                  s1_axi_rvalid,
  input  logic                  s1_axi_rready,
  // downstream RAM
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  // Selected port while busy; in IDLE the same bit is the last-granted pointer.
  logic     w_sel_q, w_sel_d;
  logic     r_sel_q, r_sel_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      w_sel_q   <= 1'b1;
      r_sel_q   <= 1'b1;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      w_sel_q   <= w_sel_d;
      r_sel_q   <= r_sel_d;
    end
  end

  // Next-state: port 1 wins if it is the lone requester or port 0 was granted last.
  always_comb begin
    w_state_d = w_state_q;
    w_sel_d   = w_sel_q;
    unique case (w_state_q)
      W_IDLE: if (s0_axi_awvalid || s1_axi_awvalid) begin
        w_sel_d   = s1_axi_awvalid && (!s0_axi_awvalid || !w_sel_q);
        w_state_d = W_ADDR;
      end
      W_ADDR: if (m_axi_awvalid && m_axi_awready) w_state_d = W_DATA;
      W_DATA: if (m_axi_wvalid && m_axi_wready && m_axi_wlast) w_state_d = W_RESP;
      W_RESP: if (m_axi_bvalid && m_axi_bready) w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    r_sel_d   = r_sel_q;
    unique case (r_state_q)
      R_IDLE: if (s0_axi_arvalid || s1_axi_arvalid) begin
        r_sel_d   = s1_axi_arvalid && (!s0_axi_arvalid || !r_sel_q);
        r_state_d = R_ADDR;
      end
      R_ADDR: if (m_axi_arvalid && m_axi_arready) r_state_d = R_DATA;
      R_DATA: if (m_axi_rvalid && m_axi_rready && m_axi_rlast) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write outputs: payload always muxed, handshakes gated by state and grant.
  always_comb begin
    m_axi_awid     = w_sel_q ? s1_axi_awid    : s0_axi_awid;
    m_axi_awaddr   = w_sel_q ? s1_axi_awaddr  : s0_axi_awaddr;
    m_axi_awlen    = w_sel_q ? s1_axi_awlen   : s0_axi_awlen;
    m_axi_awsize   = w_sel_q ? s1_axi_awsize  : s0_axi_awsize;
    m_axi_awburst  = w_sel_q ? s1_axi_awburst : s0_axi_awburst;
    m_axi_awlock   = w_sel_q ? s1_axi_awlock  : s0_axi_awlock;
    m_axi_awcache  = w_sel_q ? s1_axi_awcache : s0_axi_awcache;
    m_axi_awprot   = w_sel_q ? s1_axi_awprot  : s0_axi_awprot;
    m_axi_wdata    = w_sel_q ? s1_axi_wdata   : s0_axi_wdata;
    m_axi_wstrb    = w_sel_q ? s1_axi_wstrb   : s0_axi_wstrb;
    m_axi_wlast    = w_sel_q ? s1_axi_wlast   : s0_axi_wlast;
    s0_axi_bid     = m_axi_bid;
    s1_axi_bid     = m_axi_bid;
    s0_axi_bresp   = m_axi_bresp;
    s1_axi_bresp   = m_axi_bresp;
    m_axi_awvalid  = 1'b0;
    m_axi_wvalid   = 1'b0;
    m_axi_bready   = 1'b0;
    s0_axi_awready = 1'b0;
    s1_axi_awready = 1'b0;
    s0_axi_wready  = 1'b0;
    s1_axi_wready  = 1'b0;
    s0_axi_bvalid  = 1'b0;
    s1_axi_bvalid  = 1'b0;
    unique case (w_state_q)
      W_ADDR: begin
        m_axi_awvalid  = w_sel_q ? s1_axi_awvalid : s0_axi_awvalid;
        s0_axi_awready = !w_sel_q && m_axi_awready;
        s1_axi_awready = w_sel_q && m_axi_awready;
      end
      W_DATA: begin
        m_axi_wvalid  = w_sel_q ? s1_axi_wvalid : s0_axi_wvalid;
        s0_axi_wready = !w_sel_q && m_axi_wready;
        s1_axi_wready = w_sel_q && m_axi_wready;
      end
      W_RESP: begin
        m_axi_bready  = w_sel_q ? s1_axi_bready : s0_axi_bready;
        s0_axi_bvalid = !w_sel_q && m_axi_bvalid;
        s1_axi_bvalid = w_sel_q && m_axi_bvalid;
      end
      default: ;
    endcase
  end

  always_comb begin
    m_axi_arid     = r_sel_q ? s1_axi_arid    : s0_axi_arid;
    m_axi_araddr   = r_sel_q ? s1_axi_araddr  : s0_axi_araddr;
    m_axi_arlen    = r_sel_q ? s1_axi_arlen   : s0_axi_arlen;
    m_axi_arsize   = r_sel_q ? s1_axi_arsize  : s0_axi_arsize;
    m_axi_arburst  = r_sel_q ? s1_axi_arburst : s0_axi_arburst;
    m_axi_arlock   = r_sel_q ? s1_axi_arlock  : s0_axi_arlock;
    m_axi_arcache  = r_sel_q ? s1_axi_arcache : s0_axi_arcache;
    m_axi_arprot   = r_sel_q ? s1_axi_arprot  : s0_axi_arprot;
    s0_axi_rid     = m_axi_rid;
    s1_axi_rid     = m_axi_rid;
    s0_axi_rdata   = m_axi_rdata;
    s1_axi_rdata   = m_axi_rdata;
    s0_axi_rresp   = m_axi_rresp;
    s1_axi_rresp   = m_axi_rresp;
    s0_axi_rlast   = m_axi_rlast;
    s1_axi_rlast   = m_axi_rlast;
    m_axi_arvalid  = 1'b0;
    m_axi_rready   = 1'b0;
    s0_axi_arready = 1'b0;
    s1_axi_arready = 1'b0;
    s0_axi_rvalid  = 1'b0;
    s1_axi_rvalid  = 1'b0;
    unique case (r_state_q)
      R_ADDR: begin
        m_axi_arvalid  = r_sel_q ? s1_axi_arvalid : s0_axi_arvalid;
        s0_axi_arready = !r_sel_q && m_axi_arready;
        s1_axi_arready = r_sel_q && m_axi_arready;
      end
      R_DATA: begin
        m_axi_rready  = r_sel_q ? s1_axi_rready : s0_axi_rready;
        s0_axi_rvalid = !r_sel_q && m_axi_rvalid;
        s1_axi_rvalid = r_sel_q && m_axi_rvalid;
      end
      default: ;
    endcase
  end

endmodule
